// File: rtl/mem_bus_arbiter.sv
// Two-port (fetch/data) arbiter and start/busy sequencer in front of the memory unit.
// One word per grant, one-cycle ack, sticky timeout flag with drain recovery.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 4095
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_q,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_d,
  input  logic              d_we,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_q,
  output logic [ADDR_W-1:0] mu_address,
  output logic [DATA_W-1:0] mu_data,
  output logic              mu_we,
  output logic              mu_start,
  input  logic              mu_busy,
  input  logic [DATA_W-1:0] mu_q,
  input  logic              mu_initDone,
  output logic              err_timeout
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE,
    RESP,
    DRAIN
  } state_t;

  localparam logic [11:0] LP_TO = 12'(TIMEOUT);

  state_t            r_state, w_state;
  logic              r_last_d, w_last_d;
  logic              r_gnt_d, w_gnt_d;
  logic [11:0]       r_timer, w_timer;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_data, w_data;
  logic              r_we, w_we;
  logic              r_start, w_start;
  logic              r_if_ack, w_if_ack;
  logic              r_d_ack, w_d_ack;
  logic [DATA_W-1:0] r_if_q, w_if_q;
  logic [DATA_W-1:0] r_d_q, w_d_q;
  logic              r_err, w_err;
  logic              w_pick_d;
  logic              w_fin;
  logic [DATA_W-1:0] w_fin_q;

  // on a tie, the port not granted last wins
  assign w_pick_d = d_req & (~if_req | ~r_last_d);

  always_comb begin
    w_state  = r_state;
    w_last_d = r_last_d;
    w_gnt_d  = r_gnt_d;
    w_timer  = r_timer;
    w_addr   = r_addr;
    w_data   = r_data;
    w_we     = r_we;
    w_start  = r_start;
    w_if_ack = 1'b0;
    w_d_ack  = 1'b0;
    w_if_q   = r_if_q;
    w_d_q    = r_d_q;
    w_err    = r_err;
    w_fin    = 1'b0;
    w_fin_q  = '0;
    unique case (r_state)
      IDLE: begin
        if (mu_initDone && (if_req || d_req)) begin
          w_gnt_d  = w_pick_d;
          w_last_d = w_pick_d;
          w_addr   = w_pick_d ? d_addr : if_addr;
          w_we     = w_pick_d & d_we;
          w_data   = (w_pick_d && d_we) ? d_d : '0;
          w_start  = 1'b1;
          w_timer  = '0;
          w_state  = WAIT_BUSY;
        end
      end
      WAIT_BUSY, WAIT_DONE: begin
        if (r_timer == LP_TO) begin
          w_fin   = 1'b1;
          w_fin_q = '1;
          w_err   = 1'b1;
          w_state = DRAIN;
        end else begin
          w_timer = r_timer + 12'd1;
          if (r_state == WAIT_BUSY) begin
            if (mu_busy) w_state = WAIT_DONE;
          end else if (!mu_busy) begin
            w_fin   = 1'b1;
            w_fin_q = mu_q;
            w_state = RESP;
          end
        end
      end
      RESP: w_state = IDLE;
      DRAIN: begin
        if (!mu_busy) w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
    // we/data must never linger once start is dropped
    if (w_fin) begin
      w_start = 1'b0;
      w_we    = 1'b0;
      w_data  = '0;
      if (r_gnt_d) begin
        w_d_ack = 1'b1;
        w_d_q   = w_fin_q;
      end else begin
        w_if_ack = 1'b1;
        w_if_q   = w_fin_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
      r_gnt_d  <= 1'b0;
      r_timer  <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_we     <= 1'b0;
      r_start  <= 1'b0;
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      r_if_q   <= '0;
      r_d_q    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_last_d <= w_last_d;
      r_gnt_d  <= w_gnt_d;
      r_timer  <= w_timer;
      r_addr   <= w_addr;
      r_data   <= w_data;
      r_we     <= w_we;
      r_start  <= w_start;
      r_if_ack <= w_if_ack;
      r_d_ack  <= w_d_ack;
      r_if_q   <= w_if_q;
      r_d_q    <= w_d_q;
      r_err    <= w_err;
    end
  end

  assign mu_address  = r_addr;
  assign mu_data     = r_data;
  assign mu_we       = r_we;
  assign mu_start    = r_start;
  assign if_ack      = r_if_ack;
  assign if_q        = r_if_q;
  assign d_ack       = r_d_ack;
  assign d_q         = r_d_q;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: memory-unit model plus per-port scoreboard queues.
// Directed tests: init gating, write, tie alternation, slow device, timeout, reset.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [26:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_q;
  logic        d_req = 1'b0;
  logic [26:0] d_addr = '0;
  logic [31:0] d_d = '0;
  logic        d_we = 1'b0;
  logic        d_ack;
  logic [31:0] d_q;
  logic [26:0] mu_address;
  logic [31:0] mu_data;
  logic        mu_we;
  logic        mu_start;
  logic        mu_busy = 1'b0;
  logic [31:0] mu_q = '0;
  logic        mu_initDone = 1'b0;
  logic        err_timeout;

  int total = 0;
  int bad = 0;

  logic [31:0] exp_if[$];
  logic [31:0] exp_d[$];
  bit          ack_log[$];
  bit          saw_we = 0;
  bit          we_bad = 0;

  int m_len = 1;
  int m_cnt = 0;
  bit m_armed = 1;
  bit m_dead = 0;
  bit m_sdram = 0;

  mem_bus_arbiter #(
    .ADDR_W (27),
    .DATA_W (32),
    .TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_ack     (if_ack),
    .if_q       (if_q),
    .d_req      (d_req),
    .d_addr     (d_addr),
    .d_d        (d_d),
    .d_we       (d_we),
    .d_ack      (d_ack),
    .d_q        (d_q),
    .mu_address (mu_address),
    .mu_data    (mu_data),
    .mu_we      (mu_we),
    .mu_start   (mu_start),
    .mu_busy    (mu_busy),
    .mu_q       (mu_q),
    .mu_initDone(mu_initDone),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  // memory unit: busy rises/falls on falling edges, needs start low to re-arm
  always @(negedge clk) begin
    if (!reset) begin
      mu_busy = 1'b0;
      m_cnt = 0;
      m_armed = 1;
    end else if (mu_busy) begin
      if (m_cnt <= 1) mu_busy = 1'b0;
      else m_cnt--;
    end else if (mu_start && m_armed && !m_dead) begin
      mu_busy = 1'b1;
      m_cnt = m_len;
      m_armed = 0;
      mu_q = m_sdram ? 32'hDEADBEEF : (32'h5A000000 ^ {5'b0, mu_address});
    end else if (!mu_start) begin
      m_armed = 1;
    end
  end

  // monitor: pop the expected word whenever an ack appears
  always @(posedge clk) begin
    #1;
    if (mu_we) saw_we = 1;
    if ((mu_we || mu_data != 0) && !mu_start) we_bad = 1;
    if (if_ack) begin
      ack_log.push_back(1'b0);
      if (exp_if.size() == 0) begin
        total++;
        bad++;
        $display("FAIL if_unexpected_ack: got q=%h want no ack", if_q);
      end else chk("if_q", if_q, exp_if.pop_front());
    end
    if (d_ack) begin
      ack_log.push_back(1'b1);
      if (exp_d.size() == 0) begin
        total++;
        bad++;
        $display("FAIL d_unexpected_ack: got q=%h want no ack", d_q);
      end else chk("d_q", d_q, exp_d.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit dp, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(dp ? d_ack : if_ack) && n < 200);
    if (!(dp ? d_ack : if_ack)) chk("ack_wait", 32'(n), 32'hFFFF);
  endtask

  task automatic req_loop(input bit dp);
    int n;
    for (int k = 0; k < 3; k++) begin
      if (dp) begin
        exp_d.push_back(32'h5A000200);
        d_addr = 27'h000200;
        d_we = 1'b0;
        d_req = 1'b1;
      end else begin
        exp_if.push_back(32'h5A000100);
        if_addr = 27'h000100;
        if_req = 1'b1;
      end
      wait_ack(dp, n);
      if (dp) d_req = 1'b0;
      else if_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit flag;
    idle(3);
    chk("rst_ctl", 32'({if_ack, d_ack, mu_start, mu_we, err_timeout}), 32'h0);
    chk("rst_addr", 32'(mu_address), 32'h0);
    reset = 1'b1;
    idle(2);

    // init gating
    exp_d.push_back(32'h5A000040);
    d_addr = 27'h000040;
    d_req = 1'b1;
    flag = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (mu_start) flag = 1;
    end
    chk("init_gate", 32'(flag), 32'h0);
    mu_initDone = 1'b1;
    idle(1);
    chk("start_after_init", 32'(mu_start), 32'h1);
    wait_ack(1, n);
    chk("init_lat", 32'(n), 32'd2);
    d_req = 1'b0;
    idle(3);

    // data write
    saw_we = 0;
    exp_d.push_back(32'h5AC02630);
    d_addr = 27'hC02630;
    d_d = 32'h0000AB00;
    d_we = 1'b1;
    d_req = 1'b1;
    wait_ack(1, n);
    chk("wr_lat", 32'(n), 32'd3);
    chk("wr_we_seen", 32'(saw_we), 32'h1);
    chk("wr_we_after", 32'(mu_we), 32'h0);
    d_req = 1'b0;
    d_we = 1'b0;
    d_d = '0;
    idle(3);
    chk("wr_we_no_start", 32'(we_bad), 32'h0);

    // tie alternation from reset
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(2);
    ack_log.delete();
    fork
      req_loop(1'b1);
      req_loop(1'b0);
    join
    idle(3);
    chk("order_len", 32'(ack_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < ack_log.size(); i++)
      chk("order", 32'(ack_log[i]), (i % 2 == 0) ? 32'h1 : 32'h0);

    // slow device, 9-cycle busy
    m_len = 9;
    m_sdram = 1;
    exp_if.push_back(32'hDEADBEEF);
    if_addr = 27'h000300;
    if_req = 1'b1;
    n = 0;
    flag = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (!if_ack && !mu_start) flag = 1;
    end while (!if_ack && n < 200);
    chk("sdram_ack", 32'(if_ack), 32'h1);
    chk("sdram_lat", 32'(n), 32'd11);
    chk("sdram_start_held", 32'(flag), 32'h0);
    if_req = 1'b0;
    m_sdram = 0;
    m_len = 1;
    idle(3);

    // timeout: device never answers
    m_dead = 1;
    exp_d.push_back(32'hFFFFFFFF);
    d_addr = 27'h000400;
    d_req = 1'b1;
    chk("err_before", 32'(err_timeout), 32'h0);
    wait_ack(1, n);
    chk("to_lat", 32'(n), 32'd18);
    chk("to_err", 32'(err_timeout), 32'h1);
    chk("to_start", 32'(mu_start), 32'h0);
    d_req = 1'b0;
    m_dead = 0;
    idle(5);
    chk("to_err_sticky", 32'(err_timeout), 32'h1);

    // reset mid-transaction
    m_len = 9;
    if_addr = 27'h000500;
    if_req = 1'b1;
    idle(4);
    reset = 1'b0;
    #1;
    chk("arst_ctl", 32'({if_ack, d_ack, mu_start, mu_we, err_timeout}), 32'h0);
    chk("arst_bus", 32'(mu_address) | mu_data | if_q | d_q, 32'h0);
    if_req = 1'b0;
    idle(2);
    reset = 1'b1;
    m_len = 1;
    idle(2);
    chk("arst_err", 32'(err_timeout), 32'h0);
    exp_if.push_back(32'h5A000600);
    if_addr = 27'h000600;
    if_req = 1'b1;
    wait_ack(0, n);
    chk("post_rst_lat", 32'(n), 32'd3);
    chk("post_rst_err", 32'(err_timeout), 32'h0);
    if_req = 1'b0;
    idle(5);

    chk("pending", 32'(exp_if.size() + exp_d.size()), 32'h0);
    chk("we_no_start", 32'(we_bad), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter and handshake sequencer placed directly upstream of the memory unit. It accepts single-word requests from the CPU instruction-fetch port and the data-memory port, and grants one at a time. It drives the memory unit's address/data/we/start bus, holding start high until busy is seen to fall. It returns the read word with a one-cycle ack, and recovers with an error flag if a transaction never completes.

## Interface
- ADDR_W, 27, address width toward memory unit
- DATA_W, 32, data width
- TIMEOUT, 4095, max cycles from start assertion to busy-low before abort (12-bit counter)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- if_req  in  1  fetch request, held high with if_addr stable until if_ack
- if_addr  in  ADDR_W  fetch word address
- if_ack  out  1  one-cycle pulse, if_q valid in same cycle
- if_q  out  DATA_W  fetched word, held until next fetch ack
- d_req  in  1  data request, held with d_addr/d_d/d_we stable until d_ack
- d_addr  in  ADDR_W  data word address
- d_d  in  DATA_W  write data
- d_we  in  1  1 = write
- d_ack  out  1  one-cycle pulse, d_q valid in same cycle
- d_q  out  DATA_W  read word (memory unit q for writes too), held until next data ack
- mu_address  out  ADDR_W  to memory unit address
- mu_data  out  DATA_W  to memory unit data
- mu_we  out  1  to memory unit we
- mu_start  out  1  to memory unit start
- mu_busy  in  1  memory unit busy (changes on falling edge)
- mu_q  in  DATA_W  memory unit read data
- mu_initDone  in  1  memory subsystem initialised
- err_timeout  out  1  sticky, set on any abort, cleared only by reset

## Operation
- States: IDLE, WAIT_BUSY, WAIT_DONE, RESP, DRAIN.
- IDLE: no grant while mu_initDone=0. Grant when either req is high.
  - If both are high, grant the port not granted last. The last-grant register resets to fetch, so data wins the first tie.
  - On grant, register mu_address; mu_data = d_d for a data write, else 0; mu_we = d_we for the data port, 0 for fetch. Set mu_start=1, clear timer, go WAIT_BUSY.
- WAIT_BUSY: mu_start held 1. mu_busy=1 goes to WAIT_DONE.
- WAIT_DONE: mu_start held 1 (the memory unit requires start until busy low).
  - mu_busy=0: capture mu_q into the granted port's q, pulse its ack, drop mu_start, force mu_we=0 and mu_data=0, go RESP.
- RESP: one cycle with start low. Requests are not sampled here. Go to IDLE.
- Timer increments each cycle in WAIT_BUSY/WAIT_DONE. On reaching TIMEOUT:
  - set err_timeout, drop mu_start and mu_we;
  - ack the granted port with q=32'hFFFFFFFF;
  - go DRAIN.
- DRAIN: wait for mu_busy=0, then IDLE. No grants during DRAIN.
- mu_we and mu_data are 0 outside WAIT_BUSY/WAIT_DONE. The memory unit decodes timer set and tone writes from address+we without start, so a lingering we must never reach it.
- mu_address holds its last value when idle.
- Requests are never dropped, only delayed. A req still high in the cycle after its ack counts as a new request.
- Reset (any state, mid-transaction included): all outputs 0, state IDLE, last-grant=fetch, timer 0, err_timeout 0. A transaction in flight at reset is discarded with no ack.

## Timing
- Edge E0: IDLE samples req, mu_start rises after E0.
- Fast device: busy rises at the falling edge after E0 and falls at the next falling edge.
  - E1 sees busy=1, enters WAIT_DONE.
  - E2 sees busy=0: ack high for E2–E3, start low after E2.
- Minimum request-to-ack: 2 cycles. Minimum spacing between starts: 4 cycles (E0, then RESP at E3, IDLE at E4).
- Slow device (SDRAM, flash, UART TX): ack one rising edge after busy is sampled low.
- Outputs are registered. Acks are combinationally independent of req.
- Timeout measured from the E0 edge. Abort ack is asserted the cycle after the counter equals TIMEOUT.

## Test plan
- mu_initDone=0, d_req=1 for 20 cycles -> mu_start stays 0. Set initDone=1 -> mu_start rises the cycle after sampling.
- Data write d_addr=27'hC02630, d_d=32'h0000AB00, model with 1-cycle busy -> mu_we=1 only while start=1; d_ack at E2; mu_we=0 afterwards.
- Both reqs high continuously, fetch addr 27'h000100, data addr 27'h000200 (read) -> grants alternate data, fetch, data, …; each ack carries the modelled q for its address; no ack is lost.
- SDRAM model, busy 9 cycles, mu_q=32'hDEADBEEF -> mu_start held high throughout; if_ack one cycle after busy is sampled low, if_q=32'hDEADBEEF.
- TIMEOUT=16, model never raises busy -> at cycle 17 d_ack=1, d_q=32'hFFFFFFFF, err_timeout=1 sticky, state DRAIN until busy low.
- Assert reset low during WAIT_DONE -> all outputs 0 immediately (async); after release, a new request completes normally, err_timeout=0.
